// File: rtl/spi_cmd_master.sv
// SPI mode-0 command master: turns a single command request into a short
// byte sequence (command byte plus address/data/dummy bytes) on sclk/mosi/ss,
// with inter-byte and inter-transaction gaps, and returns the last byte seen
// on miso for read-type commands.
module spi_cmd_master #(
  parameter int unsigned CLK_DIV = 6,
  parameter int unsigned GAP     = 32
) (
  input  logic        clock_50,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_data,
  output logic        busy,
  output logic        done,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        sclk,
  output logic        mosi,
  output logic        ss,
  input  logic        miso
);

  localparam int unsigned DW = $clog2(CLK_DIV);
  localparam int unsigned GW = $clog2(GAP + 1);

  localparam logic [2:0] OP_ADDR   = 3'd1;
  localparam logic [2:0] OP_READ   = 3'd3;
  localparam logic [2:0] OP_STATUS = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_GAP,
    S_HOLD,
    S_END
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q,   div_d;
  logic [2:0]    bit_q,   bit_d;
  logic [1:0]    byte_q,  byte_d;
  logic [GW-1:0] gap_q,   gap_d;
  logic          sclk_q,  sclk_d;
  logic [7:0]    tx_q,    tx_d;
  logic [7:0]    rx_q,    rx_d;
  logic [2:0]    op_q,    op_d;
  logic [15:0]   addr_q,  addr_d;
  logic [7:0]    data_q,  data_d;
  logic [7:0]    rsp_q,   rsp_d;
  logic          rst_q;

  logic div_end;
  logic last_byte;
  logic is_read;

  function automatic logic op_legal(input logic [2:0] op);
    return (op >= 3'd1) && (op <= 3'd5);
  endfunction

  // Byte idx of the transaction for the registered command.
  function automatic logic [7:0] cmd_byte(input logic [1:0]  idx,
                                          input logic [2:0]  op,
                                          input logic [15:0] addr,
                                          input logic [7:0]  data);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      2'd0: b = {5'b0, op};
      2'd1: begin
        if (op == OP_ADDR)                         b = addr[15:8];
        else if ((op == OP_READ) || (op == OP_STATUS)) b = 8'h00;
        else                                       b = data;
      end
      2'd2: b = addr[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  assign div_end   = (div_q == DW'(CLK_DIV - 1));
  assign last_byte = (byte_q == ((op_q == OP_ADDR) ? 2'd2 : 2'd1));
  assign is_read   = (op_q == OP_READ) || (op_q == OP_STATUS);

  // Next-state and datapath update for the transaction sequencer.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    gap_d   = gap_q;
    sclk_d  = sclk_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    op_d    = op_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rsp_d   = rsp_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_d   = cmd_op;
          addr_d = cmd_addr;
          data_d = cmd_data;
          if (op_legal(cmd_op)) begin
            state_d = S_SETUP;
            div_d   = '0;
            bit_d   = '0;
            byte_d  = '0;
            sclk_d  = 1'b0;
            tx_d    = {5'b0, cmd_op};
          end else begin
            state_d = S_END;
            gap_d   = '0;
          end
        end
      end

      S_SETUP: begin
        if (div_end) begin
          div_d   = '0;
          sclk_d  = 1'b1;
          rx_d    = {rx_q[6:0], miso};
          state_d = S_SHIFT;
        end else begin
          div_d = div_q + DW'(1);
        end
      end

      // SHIFT covers both sclk phases; sclk_q tells which half we are in.
      S_SHIFT: begin
        if (div_end) begin
          div_d = '0;
          if (sclk_q) begin
            sclk_d = 1'b0;
            if (bit_q == 3'd7) begin
              bit_d = '0;
              gap_d = '0;
              state_d = last_byte ? S_HOLD : S_GAP;
            end else begin
              bit_d = bit_q + 3'd1;
              tx_d  = {tx_q[6:0], 1'b0};
            end
          end else begin
            sclk_d = 1'b1;
            rx_d   = {rx_q[6:0], miso};
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end

      S_GAP: begin
        if (gap_q == GW'(GAP - 1)) begin
          state_d = S_SETUP;
          div_d   = '0;
          byte_d  = byte_q + 2'd1;
          tx_d    = cmd_byte(byte_q + 2'd1, op_q, addr_q, data_q);
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end

      S_HOLD: begin
        if (div_end) begin
          state_d = S_END;
          gap_d   = '0;
          if (is_read) rsp_d = rx_q;
        end else begin
          div_d = div_q + DW'(1);
        end
      end

      // First END cycle carries done; the remaining GAP cycles keep ss high.
      S_END: begin
        if (!op_legal(op_q) || (gap_q == GW'(GAP))) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock_50) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      gap_q   <= '0;
      sclk_q  <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      op_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rsp_q   <= '0;
      rst_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      gap_q   <= gap_d;
      sclk_q  <= sclk_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rsp_q   <= rsp_d;
      rst_q   <= 1'b0;
    end
  end

  // Outputs decoded from registered state; rst_q keeps cmd_ready low for the
  // cycle following each reset edge.
  always_comb begin
    cmd_ready = (state_q == S_IDLE) && !rst_q;
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_END) && (gap_q == '0);
    rsp_valid = done && is_read;
    rsp_data  = rsp_q;
    sclk      = sclk_q;
    ss        = !((state_q == S_SETUP) || (state_q == S_SHIFT) ||
                  (state_q == S_GAP)   || (state_q == S_HOLD));
    mosi      = ((state_q == S_SETUP) || (state_q == S_SHIFT)) ? tx_q[7] : 1'b0;
  end

endmodule

// File: tb/tb_spi_cmd_master.sv
// Self-checking bench for spi_cmd_master: table of commands run through a
// SPI slave model with byte/response scoreboards, plus hand-written
// sequences for back-to-back, mid-transaction reset and illegal opcodes.
`timescale 1ns/1ps
module tb_spi_cmd_master;

  localparam int unsigned CD = 2;
  localparam int unsigned GP = 4;

  logic        clock_50 = 1'b0;
  logic        reset_n  = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd_op   = '0;
  logic [15:0] cmd_addr = '0;
  logic [7:0]  cmd_data = '0;
  logic        miso;
  logic        cmd_ready, busy, done, rsp_valid, sclk, mosi, ss;
  logic [7:0]  rsp_data;

  always #5 clock_50 = ~clock_50;

  spi_cmd_master #(.CLK_DIV(CD), .GAP(GP)) dut (
    .clock_50  (clock_50),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .busy      (busy),
    .done      (done),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .sclk      (sclk),
    .mosi      (mosi),
    .ss        (ss),
    .miso      (miso)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_true(input string name, input logic cond, input logic [31:0] act);
    tests++;
    if (cond !== 1'b1) begin
      fails++;
      $display("FAIL %s: condition false, observed value 0x%0h", name, act);
    end
  endtask

  // Scoreboards and slave model state
  logic [7:0]  exp_bytes[$];
  logic [7:0]  exp_rsp[$];
  logic [7:0]  slave_resp[3];
  int unsigned mon_bit = 0, mon_byte = 0, rbit = 0;
  int unsigned rise_total = 0, done_total = 0, acc_total = 0;
  int unsigned ss_high_run = 0, ss_rise_total = 0;
  logic [7:0]  mon_sh = '0;
  logic [7:0]  mon_e;
  logic        sclk_p = 1'b0, ss_p = 1'b1, mosi_p = 1'b0;

  // Slave drives the current bit of the current response byte.
  always_comb begin
    logic [7:0] b;
    b = (mon_byte < 3) ? slave_resp[mon_byte[1:0]] : 8'h00;
    miso = b[3'(7 - mon_bit)];
  end

  // Monitor sampled on the falling clock edge, away from DUT updates.
  always @(negedge clock_50) begin
    if (!ss && ss_p) check_true("ss_high_gap", ss_high_run >= GP, ss_high_run);
    if (ss && !ss_p) ss_rise_total++;
    if (ss) ss_high_run++; else ss_high_run = 0;
    check_true("sclk_idle_low", !(ss && sclk), {30'b0, ss, sclk});
    if (ss) begin
      mon_bit = 0; mon_byte = 0; rbit = 0;
    end else begin
      if (sclk && !sclk_p) begin
        rise_total++;
        mon_sh = {mon_sh[6:0], mosi};
        rbit++;
        if (rbit == 8) begin
          rbit = 0;
          if (exp_bytes.size() == 0) begin
            check_true("unexpected_mosi_byte", 1'b0, mon_sh);
          end else begin
            mon_e = exp_bytes.pop_front();
            check("mosi_byte", mon_sh, mon_e);
          end
        end
      end
      if (!sclk && sclk_p) begin
        mon_bit++;
        if (mon_bit == 8) begin mon_bit = 0; mon_byte++; end
      end
      if (sclk && sclk_p) check("mosi_stable_high", mosi, mosi_p);
    end
    if (done) done_total++;
    if (rsp_valid) begin
      check("rsp_with_done", done, 1'b1);
      if (exp_rsp.size() == 0) begin
        check_true("unexpected_rsp", 1'b0, rsp_data);
      end else begin
        mon_e = exp_rsp.pop_front();
        check("rsp_data_sb", rsp_data, mon_e);
      end
    end
    if (cmd_valid && cmd_ready) acc_total++;
    sclk_p = sclk; ss_p = ss; mosi_p = mosi;
  end

  typedef struct {
    logic [2:0]  op;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [7:0]  resp;
    int unsigned rises;
    int unsigned lat;
    logic        rv;
  } vec_t;

  vec_t       vecs[7];
  logic [7:0] model_rsp = 8'h00;

  function automatic int unsigned lat_of(input int unsigned nb);
    return 1 + nb * 16 * CD + (nb - 1) * GP + CD;
  endfunction

  task automatic tick();
    @(posedge clock_50); #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 500) begin tick(); n++; end
    check_true("ready_timeout", cmd_ready, n);
  endtask

  task automatic push_bytes(input logic [2:0] op, input logic [15:0] addr, input logic [7:0] data);
    exp_bytes.push_back({5'b0, op});
    case (op)
      3'd1: begin exp_bytes.push_back(addr[15:8]); exp_bytes.push_back(addr[7:0]); end
      3'd2, 3'd5: exp_bytes.push_back(data);
      default: exp_bytes.push_back(8'h00);
    endcase
  endtask

  task automatic run_cmd(input vec_t v);
    int unsigned r0, d0, s0, lat, gap;
    slave_resp[0] = 8'h5A; slave_resp[1] = v.resp; slave_resp[2] = 8'hC3;
    wait_ready();
    push_bytes(v.op, v.addr, v.data);
    if (v.rv) begin exp_rsp.push_back(v.resp); model_rsp = v.resp; end
    r0 = rise_total; d0 = done_total; s0 = ss_rise_total;
    cmd_valid = 1'b1; cmd_op = v.op; cmd_addr = v.addr; cmd_data = v.data;
    tick();
    cmd_valid = 1'b0;
    cmd_op = 3'($urandom); cmd_addr = 16'($urandom); cmd_data = 8'($urandom);
    check("setup_ss", ss, 1'b0);
    check("setup_sclk", sclk, 1'b0);
    check("setup_busy", busy, 1'b1);
    lat = 1;
    while (!done && lat < 2000) begin tick(); lat++; end
    check("done_latency", lat, v.lat);
    check("rsp_valid_at_done", rsp_valid, v.rv);
    check("rsp_data_at_done", rsp_data, model_rsp);
    check("ss_high_at_done", ss, 1'b1);
    gap = 0;
    while (!cmd_ready && gap < 100) begin tick(); gap++; end
    check_true("post_gap", (gap == GP) || (gap == GP + 1), gap);
    check("sclk_rises", rise_total - r0, v.rises);
    check("done_pulses", done_total - d0, 1);
    check("ss_single_window", ss_rise_total - s0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int unsigned d0, r0, a0, n;
    logic [2:0] ill[3];
    ill[0] = 3'd0; ill[1] = 3'd6; ill[2] = 3'd7;
    slave_resp[0] = 8'h00; slave_resp[1] = 8'h00; slave_resp[2] = 8'h00;

    vecs[0] = '{3'd1, 16'hFF48, 8'h00, 8'h00, 24, lat_of(3), 1'b0};
    vecs[1] = '{3'd3, 16'h0000, 8'h00, 8'hA5, 16, lat_of(2), 1'b1};
    vecs[2] = '{3'd5, 16'h0000, 8'h81, 8'h00, 16, lat_of(2), 1'b0};
    vecs[3] = '{3'd4, 16'h0000, 8'h00, 8'h04, 16, lat_of(2), 1'b1};
    vecs[4] = '{3'd2, 16'h0000, 8'h3C, 8'h77, 16, lat_of(2), 1'b0};
    vecs[5] = '{3'd1, 16'h0001, 8'hEE, 8'h00, 24, lat_of(3), 1'b0};
    vecs[6] = '{3'd3, 16'h1234, 8'h00, 8'h3C, 16, lat_of(2), 1'b1};

    // Reset state
    reset_n = 1'b0;
    tick(); tick(); tick();
    check("rst_ss", ss, 1'b1);
    check("rst_sclk", sclk, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data", rsp_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_cmd_ready", cmd_ready, 1'b0);
    reset_n = 1'b1;
    tick();
    check("ready_after_release", cmd_ready, 1'b1);

    for (int i = 0; i < 7; i++) run_cmd(vecs[i]);

    // Back-to-back WRITEs with cmd_valid held high
    wait_ready();
    push_bytes(3'd2, 16'h0, 8'h11);
    push_bytes(3'd2, 16'h0, 8'h22);
    d0 = done_total; a0 = acc_total;
    cmd_valid = 1'b1; cmd_op = 3'd2; cmd_data = 8'h11;
    tick();
    check("b2b_busy1", busy, 1'b1);
    cmd_data = 8'h22;
    n = 0;
    while (!cmd_ready && n < 500) begin tick(); n++; end
    check_true("b2b_ready2", cmd_ready, n);
    tick();
    check("b2b_busy2", busy, 1'b1);
    cmd_valid = 1'b0;
    n = 0;
    while ((done_total - d0 < 2) && n < 1000) begin tick(); n++; end
    wait_ready();
    check("b2b_done_pulses", done_total - d0, 2);
    check("b2b_accepts", acc_total - a0, 2);
    check("b2b_bytes_left", exp_bytes.size(), 0);

    // Reset during the 4th bit of byte 1 of a WRITE
    wait_ready();
    exp_bytes.push_back(8'h02);
    d0 = done_total; r0 = rise_total;
    cmd_valid = 1'b1; cmd_op = 3'd2; cmd_data = 8'h96;
    tick();
    cmd_valid = 1'b0;
    n = 0;
    while ((rise_total - r0 < 12) && n < 500) begin tick(); n++; end
    check("abort_rise_point", rise_total - r0, 12);
    reset_n = 1'b0;
    tick();
    check("abort_ss", ss, 1'b1);
    check("abort_sclk", sclk, 1'b0);
    check("abort_mosi", mosi, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_ready", cmd_ready, 1'b0);
    check("abort_done", done, 1'b0);
    tick(); tick();
    reset_n = 1'b1;
    tick();
    model_rsp = 8'h00;
    check("abort_ready_release", cmd_ready, 1'b1);
    check("abort_no_done", done_total - d0, 0);
    check("abort_bytes_left", exp_bytes.size(), 0);
    check("abort_rsp_cleared", rsp_data, 8'h00);
    run_cmd(vecs[3]);

    // Illegal opcodes
    for (int i = 0; i < 3; i++) begin
      wait_ready();
      d0 = done_total; r0 = rise_total;
      cmd_valid = 1'b1; cmd_op = ill[i];
      tick();
      cmd_valid = 1'b0;
      check("ill_done_t1", done, 1'b1);
      check("ill_rsp_valid", rsp_valid, 1'b0);
      check("ill_ss", ss, 1'b1);
      check("ill_sclk", sclk, 1'b0);
      check("ill_mosi", mosi, 1'b0);
      tick();
      check("ill_idle_t2", cmd_ready, 1'b1);
      check("ill_done_t2", done, 1'b0);
      tick();
      check("ill_no_rises", rise_total - r0, 0);
      check("ill_done_count", done_total - d0, 1);
    end

    check("bytes_drained", exp_bytes.size(), 0);
    check("rsp_drained", exp_rsp.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_cmd_master.md
SPI_CMD_MASTER -- requirements
Module: spi_cmd_master

Interface
REQ-001 Parameter CLK_DIV, 6, clock_50 cycles per sclk half-period (min 2; 6 gives ~4.17 MHz).
REQ-002 Parameter GAP, 32, clock_50 cycles between bytes and between transactions (min 1); covers the cartridge-side SRAM arbitration.
REQ-003 clock_50  in  1  single clock; every flop is clocked on its rising edge.
REQ-004 reset_n  in  1  synchronous active-low reset.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_ready  out  1  high only in IDLE; a command is accepted on a cycle where cmd_valid & cmd_ready.
REQ-007 cmd_op  in  3  1=ADDR, 2=WRITE, 3=READ, 4=READ_STATUS, 5=DEVCON; 0/6/7 illegal.
REQ-008 cmd_addr  in  16  address for ADDR.
REQ-009 cmd_data  in  8  data byte for WRITE and DEVCON.
REQ-010 busy  out  1  high whenever not in IDLE.
REQ-011 done  out  1  one-cycle pulse at the end of every accepted command.
REQ-012 rsp_valid  out  1  one-cycle pulse, READ/READ_STATUS only, coincident with done.
REQ-013 rsp_data  out  8  byte captured on miso during the final byte; held until the next rsp_valid.
REQ-014 sclk, mosi, ss  out  1 each  SPI mode 0 master; ss active low.
REQ-015 miso  in  1  SPI slave data.

Function
REQ-016 Byte sequence per op: ADDR = 8'h01, addr[15:8], addr[7:0]; WRITE = 8'h02, data; READ = 8'h03, 8'h00; READ_STATUS = 8'h04, 8'h00; DEVCON = 8'h05, data.
REQ-017 The command byte shall equal {5'b0, cmd_op}; cmd_addr, cmd_data and cmd_op shall be registered at acceptance, and later input changes shall not affect the transaction.
REQ-018 States are IDLE, SETUP, SHIFT, GAP, HOLD, END, with the transitions given in REQ-019 to REQ-025.
REQ-019 On acceptance at edge T, the block shall drive ss=0, sclk=0 and mosi=bit7 of byte 0 from T+1 (SETUP).
REQ-020 SHIFT timing:
- sclk rises after CLK_DIV cycles of SETUP.
- sclk stays high CLK_DIV cycles, then low CLK_DIV cycles.
- Byte duration is 16*CLK_DIV cycles from SETUP entry.
REQ-021 miso shall be sampled at each sclk rising edge, MSB first, into an 8-bit shift register.
REQ-022 mosi shall change only at an sclk falling edge (next bit) and hold during the high phase.
REQ-023 After the 8th falling edge of a non-final byte, the block shall enter GAP:
- ss stays 0, sclk 0, mosi 0 for GAP cycles;
- then SETUP of the next byte with mosi = its bit7.
REQ-024 After the 8th falling edge of the final byte, the block shall enter HOLD for CLK_DIV cycles with ss=0.
- Then END: ss=1 and done=1 for one cycle.
- For READ/READ_STATUS, rsp_valid=1 and rsp_data=the captured byte in that same cycle.
REQ-025 After END, the block shall keep ss=1 for GAP cycles before returning to IDLE; cmd_ready=0 throughout.
REQ-026 Exact sclk rising edges per transaction: ADDR 24, all other legal ops 16.
REQ-027 Illegal op: accepted; no ss/sclk/mosi activity; done pulses at T+1, rsp_valid stays 0, then IDLE at T+2.
REQ-028 cmd_valid held high continuously: each command is accepted only on a cmd_ready cycle, and no command is lost or duplicated.
REQ-029 Counters:
- divider counter sized for CLK_DIV;
- 3-bit bit counter;
- 2-bit byte index wrapping only via reset to 0 at SETUP of byte 0;
- gap counter sized for GAP.

Reset
REQ-030 While reset_n=0 at a clock edge, the block shall set state=IDLE, ss=1, sclk=0, mosi=0, done=0, rsp_valid=0, rsp_data=8'h00, busy=0, and cmd_ready=0 for that cycle.
REQ-031 Reset mid-transaction:
- outputs reach REQ-030 values at the next edge;
- no done or rsp_valid is issued for the aborted command;
- cmd_ready=1 on the first cycle after reset_n returns high.

Verification
REQ-032 CLK_DIV=2, GAP=4, ADDR addr=16'hFF48 -> slave model sees bytes 01, FF, 48; ss low continuously across all bytes; exactly 24 sclk rising edges; single done pulse.
REQ-033 READ with the slave model returning 8'hA5 on the second byte -> mosi bytes 03, 00; rsp_valid and done pulse together; rsp_data=8'hA5.
REQ-034 DEVCON data=8'h81, then READ_STATUS with slave returning 8'h04 -> bytes 05, 81 | 04, 00; ss high for at least GAP cycles between them; rsp_data=8'h04.
REQ-035 cmd_valid held high with two WRITE commands (data 8'h11, 8'h22) -> two transactions in order; second accepted only after GAP idle cycles; two done pulses.
REQ-036 reset_n low during the 4th bit of byte 1 of WRITE -> next edge ss=1, sclk=0, mosi=0; no done; a new command is accepted on the first cycle after release.
REQ-037 cmd_op=0 -> done at T+1; ss, sclk and mosi stay idle; rsp_valid=0.
